// File: rtl/itrx_amba3_ahblite_resp_ctl_if.sv
// AHB-Lite data-phase bundle between decoder/slaves (inputs) and the response controller.
// The slave modport is the controller's view; master is the driving side (decoder, slaves, bench).
interface itrx_amba3_ahblite_resp_ctl_if #(
  parameter int HDATAW = 64,
  parameter int NS     = 16
);
  logic [NS-1:0]        hsel;
  logic [1:0]           htrans;
  logic [NS-1:0]        s_hreadyout;
  logic [NS-1:0]        s_hresp;
  logic [NS*HDATAW-1:0] s_hrdata;
  logic                 hready;
  logic                 hresp;
  logic [HDATAW-1:0]    hrdata;

  modport slave (
    input  hsel, htrans, s_hreadyout, s_hresp, s_hrdata,
    output hready, hresp, hrdata
  );

  modport master (
    output hsel, htrans, s_hreadyout, s_hresp, s_hrdata,
    input  hready, hresp, hrdata
  );
endinterface

// File: rtl/itrx_amba3_ahblite_resp_ctl.sv
// AHB-Lite data-phase response controller: registered slave select, response mux,
// built-in two-cycle ERROR default slave and a monitor-only stall watchdog.
module itrx_amba3_ahblite_resp_ctl #(
  parameter int HDATAW = 64,
  parameter int NS     = 16,
  parameter int TMOW   = 8
) (
  input  logic                                   hclk,
  input  logic                                   hreset_n,
  itrx_amba3_ahblite_resp_ctl_if.slave           bus,
  input  logic                                   clr_err,
  output logic                                   multi_sel_err,
  output logic                                   stall_tmo
);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  localparam logic [TMOW-1:0] CNT_MAX = '1;

  ds_state_t       ds_state, ds_next;
  logic [NS-1:0]   dsel, dsel_next;
  logic [TMOW-1:0] cnt, cnt_next;
  logic [NS-1:0]   hsel_low;
  logic            capture;
  logic            multi_set;
  logic            stalling;
  logic            stall_set;

  // Two's-complement trick isolates the lowest set bit of hsel.
  assign hsel_low  = bus.hsel & (~bus.hsel + 1'b1);
  assign capture   = bus.hready;
  assign multi_set = capture && ((bus.hsel & (bus.hsel - 1'b1)) != '0);
  assign stalling  = (dsel != '0) && !bus.hready;

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      ds_state <= DS_IDLE;
      dsel     <= '0;
      cnt      <= '0;
    end else begin
      ds_state <= ds_next;
      dsel     <= dsel_next;
      cnt      <= cnt_next;
    end
  end

  always_comb begin
    ds_next   = ds_state;
    dsel_next = dsel;
    case (ds_state)
      DS_ERR1: ds_next = DS_ERR2;
      default: begin
        if (capture) begin
          dsel_next = hsel_low;
          if ((bus.hsel == '0) && bus.htrans[1]) begin
            ds_next = DS_ERR1;
          end else begin
            ds_next = DS_IDLE;
          end
        end
      end
    endcase
  end

  // ERROR states never coexist with a nonzero dsel, so the slave mux only runs in DS_IDLE.
  always_comb begin
    bus.hready = 1'b1;
    bus.hresp  = 1'b0;
    bus.hrdata = '0;
    case (ds_state)
      DS_ERR1: begin
        bus.hready = 1'b0;
        bus.hresp  = 1'b1;
      end
      DS_ERR2: begin
        bus.hresp  = 1'b1;
      end
      default: begin
        for (int i = 0; i < NS; i++) begin
          if (dsel[i]) begin
            bus.hready = bus.s_hreadyout[i];
            bus.hresp  = bus.s_hresp[i];
            bus.hrdata = bus.s_hrdata[i*HDATAW +: HDATAW];
          end
        end
      end
    endcase
  end

  always_comb begin
    cnt_next = '0;
    if (stalling) begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end
    stall_set = stalling && (cnt_next == CNT_MAX);
  end

  // Set events take priority over a same-cycle clear.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      multi_sel_err <= 1'b0;
      stall_tmo     <= 1'b0;
    end else begin
      if (multi_set) begin
        multi_sel_err <= 1'b1;
      end else if (clr_err) begin
        multi_sel_err <= 1'b0;
      end
      if (stall_set) begin
        stall_tmo <= 1'b1;
      end else if (clr_err) begin
        stall_tmo <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_itrx_amba3_ahblite_resp_ctl.sv
// Directed scoreboard bench: each step drives one cycle of inputs, queues the expected
// outputs for that cycle, then pops and checks them mid-cycle before the next edge.
module tb_itrx_amba3_ahblite_resp_ctl;

  localparam int HDATAW = 64;
  localparam int NS     = 16;
  localparam int TMOW   = 3;
  localparam logic [15:0] ALL = 16'hFFFF;

  typedef struct {
    string       tag;
    logic        rdy;
    logic        resp;
    logic [63:0] data;
    logic        multi;
    logic        stall;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic        clr_err;
  logic        multi_sel_err;
  logic        stall_tmo;
  logic [63:0] sdata [NS];
  logic        em;
  logic        es;
  exp_t        sb [$];
  int          tests_run = 0;
  int          tests_failed = 0;

  itrx_amba3_ahblite_resp_ctl_if #(.HDATAW(HDATAW), .NS(NS)) bus ();

  itrx_amba3_ahblite_resp_ctl #(.HDATAW(HDATAW), .NS(NS), .TMOW(TMOW)) dut (
    .hclk          (hclk),
    .hreset_n      (hreset_n),
    .bus           (bus),
    .clr_err       (clr_err),
    .multi_sel_err (multi_sel_err),
    .stall_tmo     (stall_tmo)
  );

  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "[TB] timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [15:0] sel, input logic [1:0] tr,
                               input logic [15:0] rdy, input logic [15:0] rsp, input logic clr,
                               input logic e_rdy, input logic e_rsp, input logic [63:0] e_data);
    exp_t e;
    bus.hsel        = sel;
    bus.htrans      = tr;
    bus.s_hreadyout = rdy;
    bus.s_hresp     = rsp;
    for (int i = 0; i < NS; i++) bus.s_hrdata[i*HDATAW +: HDATAW] = sdata[i];
    clr_err = clr;
    e.tag   = tag;
    e.rdy   = e_rdy;
    e.resp  = e_rsp;
    e.data  = e_data;
    e.multi = em;
    e.stall = es;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(negedge hclk);
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $error("[TB] FAIL scoreboard: observed empty expected entry");
    end else begin
      tests_run--;
      e = sb.pop_front();
      chk({e.tag, ".hready"}, {63'd0, bus.hready}, {63'd0, e.rdy});
      chk({e.tag, ".hresp"},  {63'd0, bus.hresp},  {63'd0, e.resp});
      chk({e.tag, ".hrdata"}, bus.hrdata, e.data);
      chk({e.tag, ".multi"},  {63'd0, multi_sel_err}, {63'd0, e.multi});
      chk({e.tag, ".stall"},  {63'd0, stall_tmo},     {63'd0, e.stall});
    end
    @(posedge hclk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NS; i++) sdata[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
    em = 1'b0;
    es = 1'b0;
    hreset_n = 1'b0;
    applyStimulus("pre", 16'h0, 2'd0, ALL, 16'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    void'(sb.pop_back());
    @(posedge hclk);
    #1;

    // Reset state, still held in reset
    applyStimulus("rst", 16'h0, 2'd0, ALL, 16'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput();
    hreset_n = 1'b1;

    // Slave 2 with two wait states
    applyStimulus("t1_addr", 16'h0004, 2'd2, ALL, 16'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput();
    sdata[2] = 64'h0;
    applyStimulus("t1_w1", 16'h0, 2'd0, ALL & ~16'h0004, 16'h0, 1'b0, 1'b0, 1'b0, sdata[2]);
    checkOutput();
    applyStimulus("t1_w2", 16'h0, 2'd0, ALL & ~16'h0004, 16'h0, 1'b0, 1'b0, 1'b0, sdata[2]);
    checkOutput();
    sdata[2] = 64'hA5;
    applyStimulus("t1_done", 16'h0, 2'd0, ALL, 16'h0, 1'b0, 1'b1, 1'b0, 64'hA5);
    checkOutput();

    // Unmapped NONSEQ -> default slave ERROR; htrans change in ERR1 ignored
    applyStimulus("t2_addr", 16'h0, 2'd2, ALL, 16'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput();
    applyStimulus("t2_err1", 16'h0001, 2'd2, ALL, 16'h0, 1'b0, 1'b0, 1'b1, 64'h0);
    checkOutput();
    applyStimulus("t2_err2", 16'h0, 2'd0, ALL, 16'h0, 1'b0, 1'b1, 1'b1, 64'h0);
    checkOutput();
    applyStimulus("t2_idle", 16'h0, 2'd0, ALL, 16'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput();

    // Back-to-back unmapped transfers
    applyStimulus("t3_a1", 16'h0, 2'd2, ALL, 16'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput();
    applyStimulus("t3_e1a", 16'h0, 2'd0, ALL, 16'h0, 1'b0, 1'b0, 1'b1, 64'h0);
    checkOutput();
    applyStimulus("t3_e2a", 16'h0, 2'd2, ALL, 16'h0, 1'b0, 1'b1, 1'b1, 64'h0);
    checkOutput();
    applyStimulus("t3_e1b", 16'h0, 2'd0, ALL, 16'h0, 1'b0, 1'b0, 1'b1, 64'h0);
    checkOutput();
    applyStimulus("t3_e2b", 16'h0, 2'd0, ALL, 16'h0, 1'b0, 1'b1, 1'b1, 64'h0);
    checkOutput();
    applyStimulus("t3_idle", 16'h0, 2'd0, ALL, 16'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput();

    // Multi-select: lowest bit wins, sticky flag, clear and set-wins-over-clear
    applyStimulus("t4_addr", 16'h0006, 2'd2, ALL, 16'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput();
    em = 1'b1;
    applyStimulus("t4_data", 16'h0, 2'd0, ALL & ~16'h0004, 16'h0004, 1'b0, 1'b1, 1'b0, sdata[1]);
    checkOutput();
    applyStimulus("t4_hold", 16'h0, 2'd0, ALL, 16'h0, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput();
    em = 1'b0;
    applyStimulus("t4_win", 16'h0003, 2'd2, ALL, 16'h0, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput();
    em = 1'b1;
    applyStimulus("t4_winchk", 16'h0, 2'd0, ALL, 16'h0, 1'b1, 1'b1, 1'b0, sdata[0]);
    checkOutput();
    em = 1'b0;
    applyStimulus("t4_after", 16'h0, 2'd0, ALL, 16'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput();

    // Watchdog: 2**3-1 = 7 wait cycles until stall_tmo
    applyStimulus("t5_addr", 16'h0001, 2'd2, ALL, 16'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput();
    for (int k = 1; k <= 9; k++) begin
      es = (k >= 8);
      applyStimulus($sformatf("t5_w%0d", k), 16'h0, 2'd0, ALL & ~16'h0001, 16'h0, 1'b0,
                    1'b0, 1'b0, sdata[0]);
      checkOutput();
    end
    applyStimulus("t5_rel", 16'h0, 2'd0, ALL, 16'h0, 1'b0, 1'b1, 1'b0, sdata[0]);
    checkOutput();
    applyStimulus("t5_clr", 16'h0, 2'd0, ALL, 16'h0, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput();
    es = 1'b0;
    applyStimulus("t5_after", 16'h0, 2'd0, ALL, 16'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput();

    // Slave two-cycle ERROR passes straight through
    applyStimulus("t7_addr", 16'h0008, 2'd2, ALL, 16'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput();
    applyStimulus("t7_e1", 16'h0, 2'd0, ALL & ~16'h0008, 16'h0008, 1'b0, 1'b0, 1'b1, sdata[3]);
    checkOutput();
    applyStimulus("t7_e2", 16'h0, 2'd0, ALL, 16'h0008, 1'b0, 1'b1, 1'b1, sdata[3]);
    checkOutput();

    // Reset asserted while the default slave is in ERR1
    applyStimulus("t6_pre", 16'h0005, 2'd2, ALL, 16'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput();
    em = 1'b1;
    applyStimulus("t6_addr", 16'h0, 2'd2, ALL, 16'h0, 1'b0, 1'b1, 1'b0, sdata[0]);
    checkOutput();
    hreset_n = 1'b0;
    applyStimulus("t6_err1", 16'h0, 2'd2, ALL, 16'h0, 1'b0, 1'b0, 1'b1, 64'h0);
    checkOutput();
    hreset_n = 1'b1;
    em = 1'b0;
    applyStimulus("t6_post", 16'h0, 2'd0, ALL, 16'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput();
    applyStimulus("t6_idle", 16'h0, 2'd0, ALL, 16'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
